// File: rtl/booth_mult.sv
// Sequential radix-2 Booth signed multiplier: one recoding step per clock, 2*WIDTH-bit product on hi/lo.
// Define BOOTH_MULT_UNSIGNED_EN to add the sign_n port (MULTU) with one extra Booth step.
module booth_mult #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef BOOTH_MULT_UNSIGNED_EN
    input  logic             sign_n,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    // state   | meaning
    // IDLE    | waiting for start, hi/lo hold the last result
    // RUN     | one Booth step per edge, counter counts down to 1
    // FINISH  | commit hi/lo and pulse done
`ifdef BOOTH_MULT_UNSIGNED_EN
    localparam int OW = WIDTH + 1;
`else
    localparam int OW = WIDTH;
`endif
    localparam int PW = 2 * OW + 1;
    localparam int CW = $clog2(OW + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [OW-1:0]    m_q, m_d;
    logic [PW-1:0]    p_q, p_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic [OW-1:0]    a_ext, b_ext;
    logic [OW:0]      p_top, m_sx, sum;
    logic [PW-1:0]    p_step;

    always_comb begin
        a_ext = A;
        b_ext = B;
`ifdef BOOTH_MULT_UNSIGNED_EN
        a_ext = sign_n ? {1'b0, A} : {A[WIDTH-1], A};
        b_ext = sign_n ? {1'b0, B} : {B[WIDTH-1], B};
`endif
    end

    // The add is one bit wider than the accumulator so M = most-negative value
    // cannot overflow; that extra bit becomes the sign shifted in on the right-shift.
    always_comb begin
        p_top = {p_q[PW-1], p_q[PW-1:OW+1]};
        m_sx  = {m_q[OW-1], m_q};
        case (p_q[1:0])
            2'b01:   sum = p_top + m_sx;
            2'b10:   sum = p_top - m_sx;
            default: sum = p_top;
        endcase
        p_step = {sum, p_q[OW:1]};
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_RUN: begin
                p_d   = p_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_FINISH;
            end
            S_FINISH: begin
                hi_d    = p_q[2*WIDTH:WIDTH+1];
                lo_d    = p_q[WIDTH:1];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A start always (re)loads; on the FINISH edge the commit above still happens.
        if (start) begin
            state_d = S_RUN;
            m_d     = a_ext;
            p_d     = {{OW{1'b0}}, b_ext, 1'b0};
            cnt_d   = CW'(OW);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = done_q;
    assign busy = (state_q == S_RUN);

endmodule

// File: tb/tb_booth_mult.sv
// Directed bench for booth_mult: vector table plus abort, restart-on-finish and reset sequences.
module tb_booth_mult;

    localparam int W = 32;
`ifdef BOOTH_MULT_UNSIGNED_EN
    localparam int LAT = W + 2;
`else
    localparam int LAT = W + 1;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  A, B;
    logic [W-1:0]  hi, lo;
    logic          busy, done;
`ifdef BOOTH_MULT_UNSIGNED_EN
    logic          sign_n = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    booth_mult #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
`ifdef BOOTH_MULT_UNSIGNED_EN
        .sign_n(sign_n),
`endif
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic kick(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Starts an op and returns edges-to-done, busy samples, result and done one edge later.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int bcnt,
                          output logic [W-1:0] rhi, output logic [W-1:0] rlo,
                          output logic d2);
        lat  = -1;
        rhi  = 'x;
        rlo  = 'x;
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        bcnt = busy ? 1 : 0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                rhi = hi;
                rlo = lo;
                break;
            end
            if (busy) bcnt++;
        end
        @(posedge clk);
        #1;
        d2 = done;
    endtask

    initial begin
        int lat, bcnt, ndone, t1, t2, bad_hold;
        logic [W-1:0] rhi, rlo, l1, l2;
        logic d2;

        vecs[0] = '{32'd7,        32'd6,        32'h00000000, 32'h0000002A};
        vecs[1] = '{32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3] = '{32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
        vecs[4] = '{32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[6] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        vecs[7] = '{32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        vecs[8] = '{32'hFFFFFFFF, 32'h80000000, 32'h00000000, 32'h80000000};

        reset = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hi",   64'(hi),   64'h0);
        chk("reset_lo",   64'(lo),   64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_done", 64'(done), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat, bcnt, rhi, rlo, d2);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(LAT));
            chk($sformatf("v%0d_hi", i), 64'(rhi), 64'(vecs[i].exp_hi));
            chk($sformatf("v%0d_lo", i), 64'(rlo), 64'(vecs[i].exp_lo));
            chk($sformatf("v%0d_done_width", i), 64'(d2), 64'h0);
            chk($sformatf("v%0d_hold_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
            if (i == 0) chk("v0_busy_cycles", 64'(bcnt), 64'(LAT - 1));
        end

        // Abort: 4x5 restarted by 9x9 at cycle 10; only one done, lo holds 6 until then.
        run_op(32'd2, 32'd3, lat, bcnt, rhi, rlo, d2);
        chk("b2b_lo", 64'(rlo), 64'd6);
        kick(32'd4, 32'd5);
        ndone = 0;
        t1 = -1;
        l1 = 'x;
        bad_hold = 0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                t1 = k;
                l1 = lo;
            end else if (ndone == 0 && lo !== 32'd6) bad_hold++;
            if (k == 9) begin
                @(negedge clk);
                A = 32'd9;
                B = 32'd9;
                start = 1'b1;
            end
            if (k == 10) begin
                @(negedge clk);
                start = 1'b0;
            end
        end
        chk("abort_done_count", 64'(ndone), 64'd1);
        chk("abort_done_time",  64'(t1),    64'(10 + LAT));
        chk("abort_lo",         64'(l1),    64'h51);
        chk("abort_hold_errs",  64'(bad_hold), 64'd0);

        // Start on the FINISH edge: 2x3 commits, then 4x4 follows.
        kick(32'd2, 32'd3);
        ndone = 0;
        t1 = -1;
        t2 = -1;
        l1 = 'x;
        l2 = 'x;
        for (int k = 1; k <= 2 * LAT + 10; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (ndone == 1) begin t1 = k; l1 = lo; end
                else begin t2 = k; l2 = lo; end
            end
            if (k == LAT - 1) begin
                @(negedge clk);
                A = 32'd4;
                B = 32'd4;
                start = 1'b1;
            end
            if (k == LAT) begin
                @(negedge clk);
                start = 1'b0;
            end
        end
        chk("fin_restart_count", 64'(ndone), 64'd2);
        chk("fin_restart_t1",    64'(t1),    64'(LAT));
        chk("fin_restart_lo1",   64'(l1),    64'd6);
        chk("fin_restart_t2",    64'(t2),    64'(2 * LAT));
        chk("fin_restart_lo2",   64'(l2),    64'd16);

        // Reset at cycle 15 of a run.
        kick(32'd3, 32'd3);
        repeat (14) @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("midreset_hi",   64'(hi),   64'h0);
        chk("midreset_lo",   64'(lo),   64'h0);
        chk("midreset_busy", 64'(busy), 64'h0);
        chk("midreset_done", 64'(done), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < LAT + 10; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("midreset_no_done", 64'(ndone), 64'd0);
        run_op(32'd5, 32'd5, lat, bcnt, rhi, rlo, d2);
        chk("post_reset_lo", 64'(rlo), 64'd25);

`ifdef BOOTH_MULT_UNSIGNED_EN
        sign_n = 1'b1;
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt, rhi, rlo, d2);
        chk("multu_latency", 64'(lat), 64'(W + 2));
        chk("multu_hi", 64'(rhi), 64'hFFFFFFFE);
        chk("multu_lo", 64'(rlo), 64'h00000001);
        sign_n = 1'b0;
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt, rhi, rlo, d2);
        chk("mult_ext_hi", 64'(rhi), 64'h0);
        chk("mult_ext_lo", 64'(rlo), 64'h1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
